// File: rtl/pattern_gen.sv
// Pixel-colour stage for a 128x128 raster: turns one (x, y) per clock into an
// RGB565 test-pattern pixel two edges later, with aligned coordinate and strobes.
module pattern_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic [1:0]  mode_in,
  output logic [15:0] pix,
  output logic [6:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic        pix_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame
);

  localparam logic [1:0] MODE_BARS     = 2'd0;
  localparam logic [1:0] MODE_CHECKER  = 2'd1;
  localparam logic [1:0] MODE_GRADIENT = 2'd2;

  logic [7:0]  frame_q, frame_d;
  logic [1:0]  mode_q, mode_d;
  logic [6:0]  x1_q, x1_d, y1_q, y1_d, f1_q, f1_d;
  logic [1:0]  m1_q, m1_d;
  logic        v1_q, v1_d;
  logic [15:0] pix_q, pix_d;
  logic [6:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        valid_q, valid_d, ls_q, ls_d, fs_q, fs_d;

  logic        eof;
  logic [6:0]  scroll_x;
  logic        on_line_x, on_line_y;
  logic [15:0] colour;

  // Frame counter and active mode advance on the EOF coordinate; stage 1
  // captures their pre-edge values so the EOF pixel still uses the old ones.
  always_comb begin
    eof     = (x == 7'd127) && (y == 7'd127);
    frame_d = eof ? frame_q + 8'd1 : frame_q;
    mode_d  = eof ? mode_in : mode_q;
    x1_d    = x;
    y1_d    = y;
    f1_d    = frame_q[6:0];
    m1_d    = mode_q;
    v1_d    = 1'b1;
  end

  always_comb begin
    colour    = 16'h0000;
    scroll_x  = x1_q + f1_q;
    on_line_x = (x1_q == 7'd0) || (x1_q == 7'd64) || (x1_q == 7'd127);
    on_line_y = (y1_q == 7'd0) || (y1_q == 7'd64) || (y1_q == 7'd127);
    case (m1_q)
      MODE_BARS: begin
        case (x1_q[6:4])
          3'd0: colour = 16'hFFFF;
          3'd1: colour = 16'hFFE0;
          3'd2: colour = 16'h07FF;
          3'd3: colour = 16'h07E0;
          3'd4: colour = 16'hF81F;
          3'd5: colour = 16'hF800;
          3'd6: colour = 16'h001F;
          default: colour = 16'h0000;
        endcase
      end
      MODE_CHECKER:  colour = (scroll_x[3] ^ y1_q[3]) ? 16'hFFFF : 16'h0000;
      MODE_GRADIENT: colour = {x1_q[6:2], y1_q[6:1], f1_q[4:0]};
      default:       colour = (on_line_x || on_line_y) ? 16'hFFFF : 16'h001F;
    endcase
  end

  // Strobes are qualified with stage-1 valid so reset-cleared zeros never
  // masquerade as a (0,0) pixel.
  always_comb begin
    pix_d   = colour;
    pix_x_d = x1_q;
    pix_y_d = y1_q;
    valid_d = v1_q;
    ls_d    = v1_q && (x1_q == 7'd0);
    fs_d    = v1_q && (x1_q == 7'd0) && (y1_q == 7'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 8'd0;
      mode_q  <= MODE_BARS;
      x1_q    <= 7'd0;
      y1_q    <= 7'd0;
      f1_q    <= 7'd0;
      m1_q    <= 2'd0;
      v1_q    <= 1'b0;
      pix_q   <= 16'h0000;
      pix_x_q <= 7'd0;
      pix_y_q <= 7'd0;
      valid_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      frame_q <= frame_d;
      mode_q  <= mode_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      f1_q    <= f1_d;
      m1_q    <= m1_d;
      v1_q    <= v1_d;
      pix_q   <= pix_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      valid_q <= valid_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign pix         = pix_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = valid_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame       = frame_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised bench for pattern_gen: a coordinate-level reference model predicts
// each pixel, strobe, valid and frame value; each scenario task checks inline.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  x = 7'd0, y = 7'd0;
  logic [1:0]  mode_in = 2'd0;
  logic [15:0] pix;
  logic [6:0]  pix_x, pix_y;
  logic        pix_valid, line_start, frame_start;
  logic [7:0]  frame;

  pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .mode_in(mode_in),
    .pix(pix), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct { int px; int cx; int cy; } exp_t;
  exp_t q[$];
  int   model_frame = 0, model_mode = 0, cyc = 0;
  int   errors = 0, checks = 0;
  logic        have_exp, exp_valid, exp_ls, exp_fs;
  logic [15:0] exp_pix;
  logic [6:0]  exp_x, exp_y;
  logic [7:0]  exp_frame;

  // Colour from the pattern rules, using bar colour components and integer arithmetic.
  function automatic logic [15:0] ref_pix(int xx, int yy, int f, int m);
    int b;
    case (m)
      0: begin
        b = xx / 16;
        return (((b % 4) < 2) ? 16'hF800 : 16'h0000) | ((b < 4) ? 16'h07E0 : 16'h0000)
             | (((b % 2) == 0) ? 16'h001F : 16'h0000);
      end
      1: return (((((xx + (f % 128)) % 128) / 8 + yy / 8) % 2) == 1) ? 16'hFFFF : 16'h0000;
      2: return 16'((xx / 4) * 2048 + (yy / 2) * 32 + (f % 32));
      default: return (xx == 0 || xx == 64 || xx == 127 || yy == 0 || yy == 64 || yy == 127)
                      ? 16'hFFFF : 16'h001F;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    model_frame = 0;
    model_mode  = 0;
    cyc         = 0;
  endtask

  // Present one coordinate, clock it, and leave the expected visible outputs in exp_*.
  task automatic step(input int xi, input int yi);
    exp_t e;
    x = 7'(xi);
    y = 7'(yi);
    e.px = int'(ref_pix(xi, yi, model_frame, model_mode));
    e.cx = xi;
    e.cy = yi;
    q.push_back(e);
    if (xi == 127 && yi == 127) begin
      model_frame = (model_frame + 1) % 256;
      model_mode  = int'(mode_in);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_valid = (cyc >= 2);
    exp_frame = 8'(model_frame);
    have_exp  = 1'b0;
    if (q.size() >= 2) begin
      e = q.pop_front();
      have_exp = 1'b1;
      exp_pix  = 16'(e.px);
      exp_x    = 7'(e.cx);
      exp_y    = 7'(e.cy);
      exp_ls   = (e.cx == 0);
      exp_fs   = (e.cx == 0) && (e.cy == 0);
    end
    $display("px in=(%0d,%0d) mode_in=%0d out=(%0d,%0d) pix=%h valid=%b ls=%b fs=%b frame=%0d",
             xi, yi, mode_in, pix_x, pix_y, pix, pix_valid, line_start, frame_start, frame);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = 7'd0; y = 7'd0; mode_in = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix, pix_x, pix_y, pix_valid, line_start, frame_start, frame} !== 43'd0) begin
      errors++;
      $display("FAIL reset_state: got pix=%h x=%0d y=%0d v=%b ls=%b fs=%b frame=%0d, want all zero",
               pix, pix_x, pix_y, pix_valid, line_start, frame_start, frame);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_bars();
    mode_in = 2'd0;
    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < 128; xx++) begin
        step(xx, yy);
        if (have_exp) begin
          checks++;
          if ({pix, pix_x, pix_y, line_start, frame_start} !== {exp_pix, exp_x, exp_y, exp_ls, exp_fs}) begin
            errors++;
            $display("FAIL bars_pixel: got pix=%h (%0d,%0d) ls=%b fs=%b, want pix=%h (%0d,%0d) ls=%b fs=%b",
                     pix, pix_x, pix_y, line_start, frame_start, exp_pix, exp_x, exp_y, exp_ls, exp_fs);
          end
        end
        checks++;
        if ({pix_valid, frame} !== {exp_valid, exp_frame}) begin
          errors++;
          $display("FAIL bars_ctrl: got valid=%b frame=%0d, want valid=%b frame=%0d",
                   pix_valid, frame, exp_valid, exp_frame);
        end
        if (cyc == 2) begin
          checks++;
          if ({pix, pix_x, pix_y, frame_start, line_start, pix_valid} !== {16'hFFFF, 7'd0, 7'd0, 3'b111}) begin
            errors++;
            $display("FAIL first_pixel: got pix=%h (%0d,%0d) fs=%b ls=%b v=%b, want FFFF (0,0) 1 1 1",
                     pix, pix_x, pix_y, frame_start, line_start, pix_valid);
          end
        end
        if (have_exp && exp_y == 7'd0 && (exp_x == 7'd80 || exp_x == 7'd127)) begin
          checks++;
          if (pix !== ((exp_x == 7'd80) ? 16'hF800 : 16'h0000)) begin
            errors++;
            $display("FAIL bar_x%0d: got %h, want %h", exp_x, pix, (exp_x == 7'd80) ? 16'hF800 : 16'h0000);
          end
        end
      end
    end
  endtask

  task automatic test_checker();
    int          px[6] = '{20, 127, 0, 8, 7, 1};
    int          py[6] = '{0, 127, 0, 0, 8, 1};
    logic [15:0] want[5] = '{16'hFFE0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    mode_in = 2'd1;
    for (int k = 0; k < 46; k++) begin
      if (k < 6) step(px[k], py[k]);
      else step(int'($urandom_range(127)), int'($urandom_range(127)));
      if (have_exp) begin
        checks++;
        if ({pix, pix_x, pix_y, line_start, frame_start} !== {exp_pix, exp_x, exp_y, exp_ls, exp_fs}) begin
          errors++;
          $display("FAIL checker_pixel: got pix=%h (%0d,%0d) ls=%b fs=%b, want pix=%h (%0d,%0d) ls=%b fs=%b",
                   pix, pix_x, pix_y, line_start, frame_start, exp_pix, exp_x, exp_y, exp_ls, exp_fs);
        end
      end
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame}) begin
        errors++;
        $display("FAIL checker_ctrl: got valid=%b frame=%0d, want valid=%b frame=%0d",
                 pix_valid, frame, exp_valid, exp_frame);
      end
      if (k >= 1 && k <= 5) begin
        checks++;
        if (pix !== want[k-1]) begin
          errors++;
          $display("FAIL checker_point%0d: got %h, want %h", k - 1, pix, want[k-1]);
        end
      end
    end
  endtask

  task automatic test_gradient();
    int          px[3] = '{127, 0, 3};
    int          py[3] = '{127, 0, 3};
    logic [15:0] want[2] = '{16'hFFE5, 16'h0006};
    int          guard = 0;
    mode_in = 2'd2;
    while ((model_frame != 5 || model_mode != 2) && guard < 600) begin
      guard++;
      step(127, 127);
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame} || (have_exp && pix !== exp_pix)) begin
        errors++;
        $display("FAIL gradient_advance: got pix=%h valid=%b frame=%0d, want pix=%h valid=%b frame=%0d",
                 pix, pix_valid, frame, exp_pix, exp_valid, exp_frame);
      end
    end
    for (int k = 0; k < 43; k++) begin
      if (k < 3) step(px[k], py[k]);
      else step(int'($urandom_range(127)), int'($urandom_range(127)));
      if (have_exp) begin
        checks++;
        if ({pix, pix_x, pix_y, line_start, frame_start} !== {exp_pix, exp_x, exp_y, exp_ls, exp_fs}) begin
          errors++;
          $display("FAIL gradient_pixel: got pix=%h (%0d,%0d) ls=%b fs=%b, want pix=%h (%0d,%0d) ls=%b fs=%b",
                   pix, pix_x, pix_y, line_start, frame_start, exp_pix, exp_x, exp_y, exp_ls, exp_fs);
        end
      end
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame}) begin
        errors++;
        $display("FAIL gradient_ctrl: got valid=%b frame=%0d, want valid=%b frame=%0d",
                 pix_valid, frame, exp_valid, exp_frame);
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (pix !== want[k-1]) begin
          errors++;
          $display("FAIL gradient_point%0d: got %h, want %h", k - 1, pix, want[k-1]);
        end
      end
    end
  endtask

  task automatic test_crosshair();
    int          px[5] = '{127, 64, 63, 127, 0};
    int          py[5] = '{127, 10, 10, 127, 5};
    logic [15:0] want[3] = '{16'hFFFF, 16'h001F, 16'hFFFF};
    mode_in = 2'd3;
    for (int k = 0; k < 45; k++) begin
      if (k < 5) step(px[k], py[k]);
      else step(int'($urandom_range(127)), int'($urandom_range(127)));
      if (have_exp) begin
        checks++;
        if ({pix, pix_x, pix_y, line_start, frame_start} !== {exp_pix, exp_x, exp_y, exp_ls, exp_fs}) begin
          errors++;
          $display("FAIL cross_pixel: got pix=%h (%0d,%0d) ls=%b fs=%b, want pix=%h (%0d,%0d) ls=%b fs=%b",
                   pix, pix_x, pix_y, line_start, frame_start, exp_pix, exp_x, exp_y, exp_ls, exp_fs);
        end
      end
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame}) begin
        errors++;
        $display("FAIL cross_ctrl: got valid=%b frame=%0d, want valid=%b frame=%0d",
                 pix_valid, frame, exp_valid, exp_frame);
      end
      if (k >= 2 && k <= 4) begin
        checks++;
        if (pix !== want[k-2]) begin
          errors++;
          $display("FAIL cross_point%0d: got %h, want %h", k - 2, pix, want[k-2]);
        end
      end
    end
  endtask

  task automatic test_mode_midframe();
    int xi, yi;
    for (int k = 0; k < 60; k++) begin
      mode_in = 2'($urandom_range(3));
      xi = int'($urandom_range(127));
      yi = int'($urandom_range(126));
      step(xi, yi);
      if (have_exp) begin
        checks++;
        if ({pix, pix_x, pix_y} !== {exp_pix, exp_x, exp_y} || (k > 0 && pix !== 16'hFFFF && pix !== 16'h001F)) begin
          errors++;
          $display("FAIL midframe_pixel: got pix=%h (%0d,%0d), want pix=%h (%0d,%0d) in crosshair",
                   pix, pix_x, pix_y, exp_pix, exp_x, exp_y);
        end
      end
    end
    mode_in = 2'd0;
    step(127, 127);
    step(80, 3);
    step(5, 5);
    checks++;
    if ({pix, frame} !== {16'hF800, exp_frame}) begin
      errors++;
      $display("FAIL midframe_switch: got pix=%h frame=%0d, want F800 frame=%0d", pix, frame, exp_frame);
    end
  endtask

  task automatic test_async_reset();
    mode_in = 2'd3;
    step(127, 127);
    step(48, 30);
    step(49, 30);
    checks++;
    if ({pix, pix_x, pix_y} !== {exp_pix, exp_x, exp_y}) begin
      errors++;
      $display("FAIL pre_reset_pixel: got pix=%h (%0d,%0d), want %h (%0d,%0d)", pix, pix_x, pix_y, exp_pix, exp_x, exp_y);
    end
    x = 7'd50; y = 7'd30;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix, pix_x, pix_y, pix_valid, line_start, frame_start, frame} !== 43'd0) begin
      errors++;
      $display("FAIL async_clear: got pix=%h (%0d,%0d) v=%b ls=%b fs=%b frame=%0d, want all zero",
               pix, pix_x, pix_y, pix_valid, line_start, frame_start, frame);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int xx = 0; xx < 24; xx++) begin
      step(xx, 0);
      if (have_exp) begin
        checks++;
        if ({pix, pix_x, pix_y, line_start, frame_start} !== {exp_pix, exp_x, exp_y, exp_ls, exp_fs}) begin
          errors++;
          $display("FAIL restart_pixel: got pix=%h (%0d,%0d) ls=%b fs=%b, want pix=%h (%0d,%0d) ls=%b fs=%b",
                   pix, pix_x, pix_y, line_start, frame_start, exp_pix, exp_x, exp_y, exp_ls, exp_fs);
        end
      end
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame}) begin
        errors++;
        $display("FAIL restart_ctrl: got valid=%b frame=%0d, want valid=%b frame=%0d",
                 pix_valid, frame, exp_valid, exp_frame);
      end
      if (have_exp && exp_x == 7'd20) begin
        checks++;
        if (pix !== 16'hFFE0) begin
          errors++;
          $display("FAIL restart_bars: got %h, want FFE0", pix);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    mode_in = 2'd0;
    for (int i = 1; i <= 256; i++) begin
      step(127, 127);
      checks++;
      if ({pix_valid, frame} !== {exp_valid, exp_frame} || (have_exp && pix !== exp_pix)) begin
        errors++;
        $display("FAIL wrap_step%0d: got pix=%h valid=%b frame=%0d, want pix=%h valid=%b frame=%0d",
                 i, pix, pix_valid, frame, exp_pix, exp_valid, exp_frame);
      end
      if (i == 255 || i == 256) begin
        checks++;
        if (frame !== ((i == 255) ? 8'd255 : 8'd0)) begin
          errors++;
          $display("FAIL wrap_eof%0d: got frame=%0d, want %0d", i, frame, (i == 255) ? 255 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_checker();
    test_gradient();
    test_crosshair();
    test_mode_midframe();
    test_async_reset();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
